// File: rtl/ram_dp_arb_ctrl.sv
// Dual-port RAM controller: zero-fill sweep after reset, then round-robin
// write/read arbitration. Option: RAM_DP_ARB_WRITE_FORWARD_EN (write fwd).
module ram_dp_arb_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic [DEPTH_LOG-1:0] req0_addr,
  input  logic [WIDTH-1:0]     req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic [DEPTH_LOG-1:0] req1_addr,
  input  logic [WIDTH-1:0]     req1_wdata,
  output logic                 rsp0_valid,
  output logic [WIDTH-1:0]     rsp0_rdata,
  output logic                 rsp1_valid,
  output logic [WIDTH-1:0]     rsp1_rdata,
  output logic                 ram_we,
  output logic [DEPTH_LOG-1:0] ram_addr_wr,
  output logic [WIDTH-1:0]     ram_data_wr,
  output logic [DEPTH_LOG-1:0] ram_addr_rd,
  input  logic [WIDTH-1:0]     ram_data_rd,
  output logic                 init_done
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam logic [DEPTH_LOG-1:0] LAST =
    DEPTH_LOG'(DEPTH - 1);

  state_t               state;
  state_t               state_nx;
  logic [DEPTH_LOG-1:0] init_cnt;
  logic [DEPTH_LOG-1:0] init_cnt_nx;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic                 run;
  logic                 wc0, wc1;
  logic                 rc0, rc1;
  logic                 wg0, wg1;
  logic                 rg0, rg1;
  logic [WIDTH-1:0]     rd_val;

  assign run = (state == RUN);

  assign wc0 = req0_valid & req0_we;
  assign wc1 = req1_valid & req1_we;
  assign rc0 = req0_valid & ~req0_we;
  assign rc1 = req1_valid & ~req1_we;

  // pointer picks the winner only when both contend
  assign wg0 = run & wc0 & (~wc1 | ~wr_ptr);
  assign wg1 = run & wc1 & (~wc0 | wr_ptr);
  assign rg0 = run & rc0 & (~rc1 | ~rd_ptr);
  assign rg1 = run & rc1 & (~rc0 | rd_ptr);

  assign req0_ready = wg0 | rg0;
  assign req1_ready = wg1 | rg1;
  assign init_done  = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nx;
      init_cnt <= init_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    ram_we      = 1'b0;
    ram_addr_wr = '0;
    ram_data_wr = '0;
    ram_addr_rd = '0;
    unique case (state)
      INIT: begin
        ram_we      = 1'b1;
        ram_addr_wr = init_cnt;
        init_cnt_nx = init_cnt + 1'b1;
        if (init_cnt == LAST) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        ram_we = wg0 | wg1;
        unique case (1'b1)
          wg0: begin
            ram_addr_wr = req0_addr;
            ram_data_wr = req0_wdata;
          end
          wg1: begin
            ram_addr_wr = req1_addr;
            ram_data_wr = req1_wdata;
          end
          default: ;
        endcase
        unique case (1'b1)
          rg0: ram_addr_rd = req0_addr;
          rg1: ram_addr_rd = req1_addr;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

`ifdef RAM_DP_ARB_WRITE_FORWARD_EN
  logic fwd_hit;
  assign fwd_hit = (wg0 | wg1) &
                   (ram_addr_wr == ram_addr_rd);
  assign rd_val  = fwd_hit ? ram_data_wr
                           : ram_data_rd;
`else
  assign rd_val = ram_data_rd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wg0) begin
        wr_ptr <= 1'b1;
      end else if (wg1) begin
        wr_ptr <= 1'b0;
      end
      if (rg0) begin
        rd_ptr <= 1'b1;
      end else if (rg1) begin
        rd_ptr <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= rg0;
      rsp1_valid <= rg1;
      if (rg0) begin
        rsp0_rdata <= rd_val;
      end
      if (rg1) begin
        rsp1_rdata <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_arb_ctrl.sv
// Randomized bench for ram_dp_arb_ctrl against a memory/arbiter model.
// Honours RAM_DP_ARB_WRITE_FORWARD_EN to match the DUT build.
module tb_ram_dp_arb_ctrl;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic          req0_we, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [W-1:0]  req0_wdata, req1_wdata;
  logic          rsp0_valid, rsp1_valid;
  logic [W-1:0]  rsp0_rdata, rsp1_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr_wr;
  logic [W-1:0]  ram_data_wr;
  logic [AW-1:0] ram_addr_rd;
  logic [W-1:0]  ram_data_rd;
  logic          init_done;

  ram_dp_arb_ctrl #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .ram_we     (ram_we),
    .ram_addr_wr(ram_addr_wr),
    .ram_data_wr(ram_data_wr),
    .ram_addr_rd(ram_addr_rd),
    .ram_data_rd(ram_data_rd),
    .init_done  (init_done)
  );

  // the physical RAM the controller drives
  logic [W-1:0] ram [D];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr_wr] <= ram_data_wr;
  end
  assign ram_data_rd = ram[ram_addr_rd];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0] ref_mem [D];
  int           w_last;
  int           r_last;
  logic [W-1:0] exp_rd0, exp_rd1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    w_last  = 1;
    r_last  = 1;
    exp_rd0 = '0;
    exp_rd1 = '0;
  endtask

  task automatic idle();
    req0_valid = 0; req0_we = 0;
    req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0;
    req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    check("rst_init_done", init_done, 0);
    check("rst_rsp0_v", rsp0_valid, 0);
    check("rst_rsp1_v", rsp1_valid, 0);
    check("rst_rsp0_d", rsp0_rdata, 0);
    check("rst_rsp1_d", rsp1_rdata, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // n cycles of the clear sweep, with requests held to prove ready=0
  task automatic sweep_n(input int n);
    for (int i = 0; i < n; i++) begin
      req0_valid = 1; req0_we = 1'($urandom);
      req0_addr = 4'($urandom); req0_wdata = 8'($urandom);
      req1_valid = 1; req1_we = 1'($urandom);
      req1_addr = 4'($urandom); req1_wdata = 8'($urandom);
      #1;
      check("sw_we", ram_we, 1);
      check("sw_addr", ram_addr_wr, i);
      check("sw_data", ram_data_wr, 0);
      check("sw_rdy0", req0_ready, 0);
      check("sw_rdy1", req1_ready, 0);
      check("sw_done", init_done, 0);
      @(negedge clk);
    end
    idle();
  endtask

  task automatic sweep();
    sweep_n(D);
    #1;
    check("init_done", init_done, 1);
    check("run_we_idle", ram_we, 0);
  endtask

  // one cycle: drive, check comb outputs, check registered responses
  task automatic step(
    input  logic v0, input logic w0,
    input  logic [AW-1:0] a0, input logic [W-1:0] d0,
    input  logic v1, input logic w1,
    input  logic [AW-1:0] a1, input logic [W-1:0] d1,
    output logic r0, output logic r1);
    logic wg0, wg1, rg0, rg1, wany;
    logic [AW-1:0] wa, ra;
    logic [W-1:0]  wd, rv;
    req0_valid = v0; req0_we = w0;
    req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1;
    req1_addr = a1; req1_wdata = d1;
    #1;
    wg0 = v0 && w0 && !(v1 && w1 && w_last == 0);
    wg1 = v1 && w1 && !(v0 && w0 && w_last == 1);
    rg0 = v0 && !w0 && !(v1 && !w1 && r_last == 0);
    rg1 = v1 && !w1 && !(v0 && !w0 && r_last == 1);
    wany = wg0 || wg1;
    wa = wg0 ? a0 : (wg1 ? a1 : '0);
    wd = wg0 ? d0 : (wg1 ? d1 : '0);
    ra = rg0 ? a0 : (rg1 ? a1 : '0);
    check("rdy0", req0_ready, wg0 | rg0);
    check("rdy1", req1_ready, wg1 | rg1);
    check("ram_we", ram_we, wany);
    check("ram_awr", ram_addr_wr, wa);
    check("ram_dwr", ram_data_wr, wd);
    check("ram_ard", ram_addr_rd, ra);
    r0 = req0_ready;
    r1 = req1_ready;
    rv = ref_mem[ra];
`ifdef RAM_DP_ARB_WRITE_FORWARD_EN
    if (wany && wa == ra) rv = wd;
`endif
    if (rg0) exp_rd0 = rv;
    if (rg1) exp_rd1 = rv;
    if (wany) ref_mem[wa] = wd;
    if (wg0) w_last = 0;
    if (wg1) w_last = 1;
    if (rg0) r_last = 0;
    if (rg1) r_last = 1;
    @(posedge clk);
    #1;
    check("rsp0_v", rsp0_valid, rg0);
    check("rsp1_v", rsp1_valid, rg1);
    check("rsp0_d", rsp0_rdata, exp_rd0);
    check("rsp1_d", rsp1_rdata, exp_rd1);
    @(negedge clk);
  endtask

  logic g0, g1;
  logic p0v, p0w, p1v, p1w;
  logic [AW-1:0] p0a, p1a;
  logic [W-1:0]  p0d, p1d;

  initial begin
    for (int i = 0; i < D; i++) ram[i] = 8'hEE;
    rst_n = 1'b0;
    model_reset();
    idle();

    // reset partway through the sweep restarts it
    do_reset();
    sweep_n(6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_done", init_done, 0);
    check("mid_rst_we", ram_we, 1);
    check("mid_rst_addr", ram_addr_wr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sweep();

    // cleared RAM reads zero
    step(1, 0, 4'd5, 8'h00, 0, 0, 4'd0, 8'h00, g0, g1);
    check("rd5_zero", rsp0_rdata, 0);

    // contending writes alternate starting with req0
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 4'd1, 8'h11, 1, 1, 4'd2, 8'h22, g0, g1);
      check("alt_g0", g0, (i % 2) == 0);
      check("alt_g1", g1, (i % 2) == 1);
    end

    // cross-class grants in one cycle
    step(1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00, g0, g1);
    step(1, 0, 4'd3, 8'h00, 1, 1, 4'd7, 8'h3C, g0, g1);
    check("x_g0", g0, 1);
    check("x_g1", g1, 1);
    check("x_rd3", rsp0_rdata, 8'hA5);
    step(0, 0, 4'd0, 8'h00, 1, 0, 4'd7, 8'h00, g0, g1);
    check("x_rd7", rsp1_rdata, 8'h3C);

    // same-address write/read collision
    step(1, 1, 4'd4, 8'h10, 0, 0, 4'd0, 8'h00, g0, g1);
    step(1, 0, 4'd4, 8'h00, 1, 1, 4'd4, 8'h99, g0, g1);
`ifdef RAM_DP_ARB_WRITE_FORWARD_EN
    check("col_rd4", rsp0_rdata, 8'h99);
`else
    check("col_rd4", rsp0_rdata, 8'h10);
`endif

    // randomized traffic, requests held until accepted
    p0v = 0; p1v = 0;
    p0w = 0; p1w = 0;
    p0a = '0; p1a = '0;
    p0d = '0; p1d = '0;
    for (int c = 0; c < 500; c++) begin
      if (!p0v && $urandom_range(0, 3) != 0) begin
        p0v = 1; p0w = 1'($urandom);
        p0a = 4'($urandom_range(0, 7));
        p0d = 8'($urandom);
      end
      if (!p1v && $urandom_range(0, 3) != 0) begin
        p1v = 1; p1w = 1'($urandom);
        p1a = 4'($urandom_range(0, 7));
        p1d = 8'($urandom);
      end
      step(p0v, p0w, p0a, p0d,
           p1v, p1w, p1a, p1d, g0, g1);
      if (g0) p0v = 0;
      if (g1) p1v = 0;
    end

    // reset during RUN with a read in flight
    step(1, 1, 4'd9, 8'h5A, 0, 0, 4'd0, 8'h00, g0, g1);
    step(1, 0, 4'd9, 8'h00, 0, 0, 4'd0, 8'h00, g0, g1);
    check("fl_v", rsp0_valid, 1);
    rst_n = 1'b0;
    #1;
    check("fl_rst_v", rsp0_valid, 0);
    check("fl_rst_d", rsp0_rdata, 0);
    check("fl_rst_done", init_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sweep();
    step(1, 1, 4'd2, 8'h77, 1, 1, 4'd3, 8'h88, g0, g1);
    check("ptr_w_g0", g0, 1);
    step(1, 0, 4'd2, 8'h00, 1, 0, 4'd3, 8'h00, g0, g1);
    check("ptr_r_g0", g0, 1);
    check("ptr_r_d", rsp0_rdata, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
